lcd_message_writer: RTL and testbench

Drives a 16x2 HD44780-compatible character LCD in 8-bit, write-only mode. It consumes the 256-bit, 32-character ASCII frame produced by the status-message formatter. It runs the LCD power-up/init sequence once, then refreshes both display lines from a snapshot of that frame, repeating forever. It sits between the combinational message formatter and the board LCD pins.

---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_message_writer_if.sv | 21 ++
 rtl/lcd_bus_cycle.sv | 93 +++++++++
 rtl/lcd_message_writer.sv | 183 ++++++++++++++++++
 tb/tb_lcd_message_writer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and state encoding for the HD44780 message writer.
// Command bytes follow the standard HD44780 instruction set in 8-bit, 2-line mode.
package lcd_pkg;

   localparam logic [7:0] LCD_FUNC_SET = 8'h38;
   localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
   localparam logic [7:0] LCD_ENTRY    = 8'h06;
   localparam logic [7:0] LCD_CLEAR    = 8'h01;
   localparam logic [7:0] LCD_LINE1    = 8'h80;
   localparam logic [7:0] LCD_LINE2    = 8'hC0;

   typedef enum logic [3:0] {
      StPowerup,
      StInit,
      StFrameStart,
      StL1Addr,
      StL1Char,
      StL2Addr,
      StL2Char,
      StFrameEnd,
      StRefreshWait
   } lcd_state_e;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lcd_message_writer_if.sv
// Frame input and LCD pin bundle of the message writer.
// master = the writer, slave = whoever supplies the frame and watches the pins.
interface lcd_message_writer_if;
   logic [255:0] message;
   logic [7:0]   lcd_data;
   logic         lcd_rs;
   logic         lcd_rw;
   logic         lcd_e;
   logic         init_done;
   logic         frame_done;

   modport master (
      input  message,
      output lcd_data, lcd_rs, lcd_rw, lcd_e, init_done, frame_done
   );

   modport slave (
      output message,
      input  lcd_data, lcd_rs, lcd_rw, lcd_e, init_done, frame_done
   );
endinterface

// File: rtl/lcd_bus_cycle.sv
// One LCD bus write: SETUP (1 cycle), E high for T_EPULSE, then a settle wait.
// done_o marks the last wait cycle so a new start can launch with no idle gap.
module lcd_bus_cycle
   import lcd_pkg::*;
#(
   parameter int unsigned T_EPULSE = 25,
   parameter int unsigned T_CMD    = 2_500,
   parameter int unsigned T_CLEAR  = 100_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic       rs_i,
   input  logic [7:0] data_i,
   output logic       done_o,
   output logic       lcd_e_o,
   output logic       lcd_rs_o,
   output logic [7:0] lcd_data_o
);

   localparam int unsigned CntW = $clog2(max3(T_EPULSE, T_CMD, T_CLEAR) + 1);

   typedef enum logic [1:0] {StIdle, StSetup, StPulse, StWait} bus_state_e;

   bus_state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            e_q, e_d;
   logic            rs_q, rs_d;
   logic [7:0]      data_q, data_d;
   logic [CntW-1:0] wait_last;
   logic            busy;

   // A 0x01 sent as character data is an ordinary write, only the command needs the long wait.
   assign wait_last = (!rs_q && data_q == LCD_CLEAR) ? CntW'(T_CLEAR - 1) : CntW'(T_CMD - 1);
   assign done_o    = (state_q == StWait) && (cnt_q == wait_last);
   assign busy      = (state_q != StIdle) && !done_o;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      e_d     = e_q;
      rs_d    = rs_q;
      data_d  = data_q;
      unique case (state_q)
         StIdle: ;
         StSetup: begin
            state_d = StPulse;
            e_d     = 1'b1;
            cnt_d   = '0;
         end
         StPulse: begin
            if (cnt_q == CntW'(T_EPULSE - 1)) begin
               state_d = StWait;
               e_d     = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StWait: begin
            if (done_o) state_d = StIdle;
            else        cnt_d   = cnt_q + CntW'(1);
         end
      endcase
      if (start_i && !busy) begin
         state_d = StSetup;
         rs_d    = rs_i;
         data_d  = data_i;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         e_q     <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         e_q     <= e_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
      end
   end

   assign lcd_e_o    = e_q;
   assign lcd_rs_o   = rs_q;
   assign lcd_data_o = data_q;

endmodule

// File: rtl/lcd_message_writer.sv
// Runs the HD44780 init sequence once, then rewrites both lines from a frame snapshot forever.
// Writes are launched from the next-state decode so consecutive writes run back to back.
module lcd_message_writer
   import lcd_pkg::*;
#(
   parameter int unsigned T_POWERUP = 1_000_000,
   parameter int unsigned T_EPULSE  = 25,
   parameter int unsigned T_CMD     = 2_500,
   parameter int unsigned T_CLEAR   = 100_000,
   parameter int unsigned T_REFRESH = 2_500_000
) (
   input logic                  clk,
   input logic                  rst_n,
   lcd_message_writer_if.master bus
);

   localparam int unsigned CntW = $clog2(max3(T_POWERUP, T_CLEAR, T_REFRESH) + 1);

   lcd_state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [4:0]      idx_q, idx_d;
   logic [1:0]      cmd_q, cmd_d;
   logic            launched_q, launched_d;
   logic            init_done_q, init_done_d;
   logic            frame_done_q, frame_done_d;
   logic [255:0]    buf_q, buf_d;

   logic            wr_start, wr_rs, wr_done, want_wr;
   logic [7:0]      wr_data;
   logic            e_w, rs_w;
   logic [7:0]      data_w;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      cmd_d        = cmd_q;
      launched_d   = launched_q;
      init_done_d  = init_done_q;
      frame_done_d = 1'b0;
      buf_d        = buf_q;
      want_wr      = 1'b0;
      wr_start     = 1'b0;
      wr_rs        = 1'b0;
      wr_data      = 8'h00;
      unique case (state_q)
         StPowerup: begin
            if (cnt_q == CntW'(T_POWERUP - 1)) begin
               state_d = StInit;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StInit: if (wr_done) begin
            launched_d = 1'b0;
            if (cmd_q == 2'd3) begin
               state_d     = StFrameStart;
               init_done_d = 1'b1;
            end else begin
               cmd_d = cmd_q + 2'd1;
            end
         end
         StFrameStart: begin
            buf_d   = bus.message;
            idx_d   = 5'd0;
            state_d = StL1Addr;
         end
         StL1Addr: if (wr_done) begin
            launched_d = 1'b0;
            state_d    = StL1Char;
         end
         StL1Char: if (wr_done) begin
            launched_d = 1'b0;
            idx_d      = idx_q + 5'd1;
            if (idx_q == 5'd15) state_d = StL2Addr;
         end
         StL2Addr: if (wr_done) begin
            launched_d = 1'b0;
            state_d    = StL2Char;
         end
         StL2Char: if (wr_done) begin
            launched_d = 1'b0;
            if (idx_q == 5'd31) begin
               state_d      = StFrameEnd;
               frame_done_d = 1'b1;
            end else begin
               idx_d = idx_q + 5'd1;
            end
         end
         StFrameEnd: begin
            state_d = StRefreshWait;
            cnt_d   = '0;
         end
         StRefreshWait: begin
            if (cnt_q == CntW'(T_REFRESH - 1)) begin
               state_d = StFrameStart;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StPowerup;
      endcase

      // Decode the write for the state being entered, so it launches in the done cycle.
      case (state_d)
         StInit: begin
            want_wr = 1'b1;
            unique case (cmd_d)
               2'd0: wr_data = LCD_FUNC_SET;
               2'd1: wr_data = LCD_DISP_ON;
               2'd2: wr_data = LCD_ENTRY;
               2'd3: wr_data = LCD_CLEAR;
            endcase
         end
         StL1Addr: begin
            want_wr = 1'b1;
            wr_data = LCD_LINE1;
         end
         StL2Addr: begin
            want_wr = 1'b1;
            wr_data = LCD_LINE2;
         end
         StL1Char, StL2Char: begin
            want_wr = 1'b1;
            wr_rs   = 1'b1;
            wr_data = buf_q[{idx_d, 3'b000} +: 8];
         end
         default: ;
      endcase
      if (want_wr && !launched_d) begin
         wr_start   = 1'b1;
         launched_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StPowerup;
         cnt_q        <= '0;
         idx_q        <= 5'd0;
         cmd_q        <= 2'd0;
         launched_q   <= 1'b0;
         init_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
         buf_q        <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         cmd_q        <= cmd_d;
         launched_q   <= launched_d;
         init_done_q  <= init_done_d;
         frame_done_q <= frame_done_d;
         buf_q        <= buf_d;
      end
   end

   lcd_bus_cycle #(
      .T_EPULSE (T_EPULSE),
      .T_CMD    (T_CMD),
      .T_CLEAR  (T_CLEAR)
   ) u_bus_cycle (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (wr_start),
      .rs_i       (wr_rs),
      .data_i     (wr_data),
      .done_o     (wr_done),
      .lcd_e_o    (e_w),
      .lcd_rs_o   (rs_w),
      .lcd_data_o (data_w)
   );

   assign bus.lcd_e      = e_w;
   assign bus.lcd_rs     = rs_w;
   assign bus.lcd_data   = data_w;
   assign bus.lcd_rw     = 1'b0;
   assign bus.init_done  = init_done_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_message_writer.sv
// Directed bench for lcd_message_writer: a negedge monitor logs every LCD write,
// the main sequence compares the log and status outputs against hand-derived values.
module tb_lcd_message_writer;

   localparam int unsigned T_POWERUP = 10;
   localparam int unsigned T_EPULSE  = 2;
   localparam int unsigned T_CMD     = 4;
   localparam int unsigned T_CLEAR   = 8;
   localparam int unsigned T_REFRESH = 20;
   localparam int unsigned SPACE     = 1 + T_EPULSE + T_CMD;

   typedef struct packed {
      logic       rs;
      logic [7:0] d;
      int         rise;
   } wr_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   lcd_message_writer_if bus ();

   lcd_message_writer #(
      .T_POWERUP (T_POWERUP),
      .T_EPULSE  (T_EPULSE),
      .T_CMD     (T_CMD),
      .T_CLEAR   (T_CLEAR),
      .T_REFRESH (T_REFRESH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   n_rise = 0;
   int   fd_total = 0;
   int   fd_cyc = 0;
   wr_t  wq[$];

   logic       prev_e = 1'b0;
   logic       rise_rs;
   logic [7:0] rise_d;
   int         rise_cyc;
   int         width;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Write log: one entry per E pulse, with rs/data seen at the rising sample.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         prev_e = 1'b0;
      end else begin
         if (bus.lcd_e && !prev_e) begin
            rise_cyc = cyc;
            rise_rs  = bus.lcd_rs;
            rise_d   = bus.lcd_data;
            width    = 1;
            n_rise++;
            chk("rw_low", {31'd0, bus.lcd_rw}, 32'd0);
         end else if (bus.lcd_e && prev_e) begin
            width++;
            chk("rs_data_stable", {23'd0, bus.lcd_rs, bus.lcd_data}, {23'd0, rise_rs, rise_d});
         end else if (!bus.lcd_e && prev_e) begin
            wr_t w;
            chk("e_width", width, T_EPULSE);
            w.rs   = rise_rs;
            w.d    = rise_d;
            w.rise = rise_cyc;
            wq.push_back(w);
         end
         if (bus.frame_done) begin
            fd_total++;
            fd_cyc = cyc;
         end
         prev_e = bus.lcd_e;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_writes(input int n, input int budget, input string tag);
      int k = 0;
      while (wq.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk(tag, {31'd0, wq.size() >= n}, 32'd1);
   endtask

   function automatic logic [255:0] str2msg(input string s);
      logic [255:0] r = '0;
      for (int i = 0; i < 32; i++) r[8*i +: 8] = s[i];
      return r;
   endfunction

   task automatic check_init(input int base, input string tag);
      logic [7:0] cmds [4];
      cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s_cmd%0d", tag, i), {23'd0, wq[base+i].rs, wq[base+i].d},
             {23'd0, 1'b0, cmds[i]});
   endtask

   task automatic check_frame(input int base, input logic [255:0] msg, input string tag);
      for (int i = 0; i < 34; i++) begin
         logic [8:0] expv;
         if (i == 0)       expv = {1'b0, 8'h80};
         else if (i < 17)  expv = {1'b1, msg[8*(i-1) +: 8]};
         else if (i == 17) expv = {1'b0, 8'hC0};
         else              expv = {1'b1, msg[8*(i-2) +: 8]};
         chk($sformatf("%s[%0d]", tag, i), {23'd0, wq[base+i].rs, wq[base+i].d}, {23'd0, expv});
      end
   endtask

   logic [255:0] msg1;
   logic [255:0] msg_a;
   int           rel;
   int           fd1;
   int           base;
   int           k;

   initial begin
      msg1  = str2msg("NS:0012 SN:0034 EW:0005 WE:0107 ");
      msg_a = {32{8'h41}};
      bus.message = msg1;

      // Reset values
      repeat (3) tick();
      chk("rst_data", {24'd0, bus.lcd_data}, 32'd0);
      chk("rst_rs", {31'd0, bus.lcd_rs}, 32'd0);
      chk("rst_rw", {31'd0, bus.lcd_rw}, 32'd0);
      chk("rst_e", {31'd0, bus.lcd_e}, 32'd0);
      chk("rst_init_done", {31'd0, bus.init_done}, 32'd0);
      chk("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);

      // Power-up wait and init sequence
      rst_n = 1'b1;
      rel = cyc;
      wait_writes(4, 200, "init_timeout");
      chk("powerup_gap", {31'd0, (wq[0].rise - rel > 10) && (wq[0].rise - rel <= 14)}, 32'd1);
      check_init(0, "init");
      chk("space_01", wq[1].rise - wq[0].rise, SPACE);
      chk("space_12", wq[2].rise - wq[1].rise, SPACE);
      chk("space_23", wq[3].rise - wq[2].rise, SPACE);
      chk("init_done_w1", {31'd0, bus.init_done}, 32'd0);
      repeat (T_CLEAR - 1) tick();
      chk("init_done_w8", {31'd0, bus.init_done}, 32'd0);
      tick();
      chk("init_done_set", {31'd0, bus.init_done}, 32'd1);

      // Frame 1
      wait_writes(38, 500, "frame1_timeout");
      check_frame(4, msg1, "f1");
      chk("space_clear", {31'd0, (wq[4].rise - wq[3].rise >= 1 + T_EPULSE + T_CLEAR) &&
                                 (wq[4].rise - wq[3].rise <= 3 + T_EPULSE + T_CLEAR)}, 32'd1);
      chk("space_l1", wq[5].rise - wq[4].rise, SPACE);
      chk("space_l2addr", wq[21].rise - wq[20].rise, SPACE);
      chk("space_l2", wq[22].rise - wq[21].rise, SPACE);
      k = 0;
      while (fd_total < 1 && k < 100) begin tick(); k++; end
      chk("fd1_seen", {31'd0, fd_total >= 1}, 32'd1);
      fd1 = fd_cyc;
      chk("fd1_after_last", {31'd0, fd1 > wq[37].rise}, 32'd1);
      repeat (3) tick();
      chk("fd1_one_cycle", fd_total, 32'd1);

      // Frame 2: switch to all 'A' while its 5th character is on the bus
      k = 0;
      while (n_rise < 44 && k < 300) begin tick(); k++; end
      chk("f2_c5_seen", {31'd0, n_rise >= 44}, 32'd1);
      bus.message = msg_a;
      wait_writes(106, 800, "frame3_timeout");
      chk("refresh_gap", {31'd0, (wq[38].rise - fd1 > T_REFRESH) &&
                                 (wq[38].rise - fd1 <= T_REFRESH + 4)}, 32'd1);
      check_frame(38, msg1, "f2");
      check_frame(72, msg_a, "f3");
      repeat (10) tick();
      chk("fd_count", fd_total, 32'd3);

      // Asynchronous reset in the middle of an E pulse
      k = 0;
      while (!bus.lcd_e && k < 100) begin tick(); k++; end
      chk("pre_rst_e", {31'd0, bus.lcd_e}, 32'd1);
      chk("pre_rst_init_done", {31'd0, bus.init_done}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_e", {31'd0, bus.lcd_e}, 32'd0);
      chk("async_init_done", {31'd0, bus.init_done}, 32'd0);
      chk("async_data", {24'd0, bus.lcd_data}, 32'd0);
      repeat (2) tick();
      base = wq.size();
      rst_n = 1'b1;
      rel = cyc;
      wait_writes(base + 5, 200, "reinit_timeout");
      chk("re_powerup_gap", {31'd0, (wq[base].rise - rel > 10) &&
                                    (wq[base].rise - rel <= 14)}, 32'd1);
      check_init(base, "reinit");
      chk("re_line1", {23'd0, wq[base+4].rs, wq[base+4].d}, {23'd0, 1'b0, 8'h80});
      chk("re_init_done", {31'd0, bus.init_done}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
